// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the write-section encodings, the arbiter state encoding and a
// word-alignment helper used when latching byte addresses into commands.
package memory_definitions;

  // Write-section encodings: bit2 high half-word, bit1 low half-word high byte,
  // bit0 low byte. All-zero means a read.
  localparam logic [2:0] WRITE_NONE = 3'b000;
  localparam logic [2:0] WRITE_BYTE = 3'b001;
  localparam logic [2:0] WRITE_HALF = 3'b011;
  localparam logic [2:0] WRITE_WORD = 3'b111;

  typedef enum logic [1:0] {
    ARBITER_IDLE  = 2'd0,
    ARBITER_ISSUE = 2'd1,
    ARBITER_WAIT  = 2'd2
  } arbiter_state_t;

  // Memory is word addressed: drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] byte_address);
    return byte_address & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/memory_arbiter_grant_selector.sv
// grant_selector: priority decision between the fetch and data ports.
// Data wins by default; once MAX_DATA_STREAK consecutive data grants have
// been given while a fetch waited, the fetch is forced through.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   fetch_request      - fetch port is requesting
//   data_request       - data port is requesting
//   grant_strobe       - high when a grant may be taken (arbiter idle)
//   grant_data         - data port wins this cycle
//   grant_fetch        - fetch port wins this cycle
module grant_selector #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fetch_request,
  input  logic data_request,
  input  logic grant_strobe,
  output logic grant_data,
  output logic grant_fetch
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_r;
  logic [3:0] streak_next_s;
  logic       limit_hit_s;

  // Priority decision and next streak value.
  always_comb begin
    limit_hit_s   = (streak_r == STREAK_LIMIT);
    grant_fetch   = fetch_request && (!data_request || limit_hit_s);
    grant_data    = data_request && !grant_fetch;
    streak_next_s = streak_r;
    if (grant_strobe && grant_data) begin
      // Only count data grants that actually made a fetch wait.
      if (fetch_request) begin
        if (limit_hit_s) begin
          streak_next_s = streak_r;
        end else begin
          streak_next_s = streak_r + 4'd1;
        end
      end else begin
        streak_next_s = 4'd0;
      end
    end else if (grant_strobe && grant_fetch) begin
      streak_next_s = 4'd0;
    end else begin
      streak_next_s = streak_r;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak_r <= 4'd0;
    end else begin
      streak_r <= streak_next_s;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch port and the load/store port. Each access is a fixed
// IDLE -> ISSUE -> WAIT sequence; the winner's operands are latched at grant.
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   fetch_request/address            - fetch port request and byte address
//   fetch_done/value                 - fetch completion pulse and read word
//   data_request/address             - data port request and byte address
//   data_write_sections/write_value  - store lane enables and store data
//   data_done/read_value             - data completion pulse and read word
//   memory_enable/address            - memory command valid and word address
//   memory_write_sections/value      - memory store lanes and data
//   memory_read_value                - memory output, valid cycle after enable
module memory_arbiter
  import memory_definitions::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_request,
  input  logic [31:0] fetch_address,
  output logic        fetch_done,
  output logic [31:0] fetch_value,
  input  logic        data_request,
  input  logic [31:0] data_address,
  input  logic [2:0]  data_write_sections,
  input  logic [31:0] data_write_value,
  output logic        data_done,
  output logic [31:0] data_read_value,
  output logic        memory_enable,
  output logic [31:0] memory_address,
  output logic [2:0]  memory_write_sections,
  output logic [31:0] memory_write_value,
  input  logic [31:0] memory_read_value
);

  arbiter_state_t state_r;
  arbiter_state_t state_next_s;
  logic           grant_strobe_s;
  logic           grant_data_s;
  logic           grant_fetch_s;
  logic           owner_data_r;
  logic [31:0]    address_r;
  logic [2:0]     sections_r;
  logic [31:0]    write_value_r;
  logic           response_s;

  grant_selector #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant_selector (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch_request(fetch_request),
    .data_request (data_request),
    .grant_strobe (grant_strobe_s),
    .grant_data   (grant_data_s),
    .grant_fetch  (grant_fetch_s)
  );

  // Next-state logic; grants are only taken while idle.
  always_comb begin
    state_next_s   = state_r;
    grant_strobe_s = 1'b0;
    case (state_r)
      ARBITER_IDLE: begin
        grant_strobe_s = 1'b1;
        if (fetch_request || data_request) begin
          state_next_s = ARBITER_ISSUE;
        end else begin
          state_next_s = ARBITER_IDLE;
        end
      end
      ARBITER_ISSUE: state_next_s = ARBITER_WAIT;
      ARBITER_WAIT:  state_next_s = ARBITER_IDLE;
      default:       state_next_s = ARBITER_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ARBITER_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command registers: latch the winner's operands at grant, hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_data_r  <= 1'b0;
      address_r     <= 32'd0;
      sections_r    <= WRITE_NONE;
      write_value_r <= 32'd0;
    end else if ((state_r == ARBITER_IDLE) && grant_data_s) begin
      owner_data_r  <= 1'b1;
      address_r     <= word_align(data_address);
      sections_r    <= data_write_sections;
      write_value_r <= data_write_value;
    end else if ((state_r == ARBITER_IDLE) && grant_fetch_s) begin
      owner_data_r  <= 1'b0;
      address_r     <= word_align(fetch_address);
      sections_r    <= WRITE_NONE;
      write_value_r <= 32'd0;
    end else begin
      owner_data_r  <= owner_data_r;
      address_r     <= address_r;
      sections_r    <= sections_r;
      write_value_r <= write_value_r;
    end
  end

  // The done pulse is suppressed while reset is asserted so a reset landing
  // in WAIT never reports a completion.
  assign response_s            = reset_n && (state_r == ARBITER_WAIT);
  assign memory_enable         = (state_r == ARBITER_ISSUE);
  assign memory_address        = address_r;
  assign memory_write_sections = sections_r;
  assign memory_write_value    = write_value_r;
  assign data_done             = response_s && owner_data_r;
  assign fetch_done            = response_s && !owner_data_r;
  assign data_read_value       = data_done ? memory_read_value : 32'd0;
  assign fetch_value           = fetch_done ? memory_read_value : 32'd0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a behavioural memory drives the
// read port, and a transaction-level reference (winner rule, streak count,
// word-array contents) predicts every command and response.
module tb_memory_arbiter;
  import memory_definitions::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_request = 1'b0;
  logic [31:0] fetch_address = 32'd0;
  logic        fetch_done;
  logic [31:0] fetch_value;
  logic        data_request = 1'b0;
  logic [31:0] data_address = 32'd0;
  logic [2:0]  data_write_sections = 3'b000;
  logic [31:0] data_write_value = 32'd0;
  logic        data_done;
  logic [31:0] data_read_value;
  logic        memory_enable;
  logic [31:0] memory_address;
  logic [2:0]  memory_write_sections;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;

  // Memory array seen by the DUT, plus a backdoor write port.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [31:0] mem_rd = 32'd0;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'd0;
  logic [31:0] bd_data = 32'd0;

  // Reference contents, updated per completed transaction.
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};
  int ref_streak = 0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .fetch_request        (fetch_request),
    .fetch_address        (fetch_address),
    .fetch_done           (fetch_done),
    .fetch_value          (fetch_value),
    .data_request         (data_request),
    .data_address         (data_address),
    .data_write_sections  (data_write_sections),
    .data_write_value     (data_write_value),
    .data_done            (data_done),
    .data_read_value      (data_read_value),
    .memory_enable        (memory_enable),
    .memory_address       (memory_address),
    .memory_write_sections(memory_write_sections),
    .memory_write_value   (memory_write_value),
    .memory_read_value    (memory_read_value)
  );

  assign memory_read_value = mem_rd;

  // Synchronous-read single-port memory.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (memory_enable) begin
      if (memory_write_sections[2]) mem[memory_address[9:2]][31:16] <= memory_write_value[31:16];
      if (memory_write_sections[1]) mem[memory_address[9:2]][15:8]  <= memory_write_value[15:8];
      if (memory_write_sections[0]) mem[memory_address[9:2]][7:0]   <= memory_write_value[7:0];
      mem_rd <= mem[memory_address[9:2]];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [2:0] sec);
    logic [31:0] r;
    r = old_w;
    if (sec[2]) r[31:16] = new_w[31:16];
    if (sec[1]) r[15:8]  = new_w[15:8];
    if (sec[0]) r[7:0]   = new_w[7:0];
    return r;
  endfunction

  task automatic backdoor(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = val;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // One complete access starting in IDLE with the current inputs. Predicts the
  // winner from the request/streak rule and checks command and response.
  task automatic do_access(input bit scramble, output bit dut_data);
    bit          exp_data;
    logic [31:0] exp_addr, exp_val, exp_rd, a;
    logic [2:0]  exp_sec;
    exp_data = data_request && (!fetch_request || ref_streak != MAX);
    if (exp_data) begin
      exp_addr = data_address & 32'hFFFF_FFFC;
      exp_sec  = data_write_sections;
      exp_val  = data_write_value;
      ref_streak = fetch_request ? ((ref_streak < MAX) ? ref_streak + 1 : MAX) : 0;
    end else begin
      exp_addr = fetch_address & 32'hFFFF_FFFC;
      exp_sec  = 3'b000;
      exp_val  = 32'd0;
      ref_streak = 0;
    end
    a = exp_addr;
    exp_rd = ref_mem[a[9:2]];
    @(posedge clk); #1;
    if (scramble) begin
      fetch_request = 1'($urandom); data_request = 1'($urandom);
      fetch_address = $urandom; data_address = $urandom;
      data_write_sections = 3'($urandom); data_write_value = $urandom;
    end
    @(negedge clk);
    tests_run++;
    if (memory_enable !== 1'b1 || memory_address !== exp_addr ||
        memory_write_sections !== exp_sec || memory_write_value !== exp_val ||
        fetch_done !== 1'b0 || data_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL issue_cmd: got en=%0b addr=%h sec=%b val=%h fd=%0b dd=%0b, expected en=1 addr=%h sec=%b val=%h no done",
               memory_enable, memory_address, memory_write_sections, memory_write_value,
               fetch_done, data_done, exp_addr, exp_sec, exp_val);
    end
    @(posedge clk);
    if (exp_sec != 3'b000) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], exp_val, exp_sec);
    @(negedge clk);
    dut_data = data_done;
    tests_run++;
    if (exp_data) begin
      if (memory_enable !== 1'b0 || data_done !== 1'b1 || fetch_done !== 1'b0 ||
          fetch_value !== 32'd0 || (exp_sec == 3'b000 && data_read_value !== exp_rd)) begin
        tests_failed++;
        $display("FAIL data_resp: got en=%0b dd=%0b fd=%0b rd=%h fv=%h, expected en=0 dd=1 fd=0 rd=%h fv=0",
                 memory_enable, data_done, fetch_done, data_read_value, fetch_value, exp_rd);
      end
    end else begin
      if (memory_enable !== 1'b0 || fetch_done !== 1'b1 || data_done !== 1'b0 ||
          fetch_value !== exp_rd || data_read_value !== 32'd0) begin
        tests_failed++;
        $display("FAIL fetch_resp: got en=%0b fd=%0b dd=%0b fv=%h rd=%h, expected en=0 fd=1 dd=0 fv=%h rd=0",
                 memory_enable, fetch_done, data_done, fetch_value, data_read_value, exp_rd);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (memory_enable !== 1'b0 || memory_address !== 32'd0 || memory_write_sections !== 3'b000 ||
        memory_write_value !== 32'd0 || fetch_done !== 1'b0 || data_done !== 1'b0 ||
        fetch_value !== 32'd0 || data_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got en=%0b addr=%h sec=%b val=%h fd=%0b dd=%0b, expected all zero",
               memory_enable, memory_address, memory_write_sections, memory_write_value, fetch_done, data_done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_streak = 0;
  endtask

  task automatic test_fetch_only();
    bit d;
    backdoor(8'h40, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    fetch_request = 1'b1; fetch_address = 32'h0000_0103; data_request = 1'b0;
    do_access(1'b0, d);
    fetch_request = 1'b0;
    @(negedge clk);
    tests_run++;
    if (memory_enable !== 1'b0 || fetch_done !== 1'b0 || data_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_quiet: got en=%0b fd=%0b dd=%0b, expected all 0", memory_enable, fetch_done, data_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    bit d;
    data_request = 1'b1; data_address = 32'h40; data_write_sections = WRITE_WORD;
    data_write_value = 32'h1234_5678;
    do_access(1'b0, d);
    data_request = 1'b0; data_write_sections = WRITE_NONE;
    tests_run++;
    if (d !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_owner: got data_done=%0b expected 1", d);
    end
  endtask

  task automatic test_streak_held(input int n);
    bit d;
    fetch_request = 1'b1; data_request = 1'b1; data_write_sections = WRITE_NONE;
    fetch_address = $urandom; data_address = $urandom;
    for (int i = 0; i < n; i++) begin
      do_access(1'b0, d);
      tests_run++;
      if (d !== ((i % 5) != 4)) begin
        tests_failed++;
        $display("FAIL streak_order[%0d]: got data=%0b expected %0b", i, d, (i % 5) != 4);
      end
    end
    fetch_request = 1'b0; data_request = 1'b0;
  endtask

  task automatic test_toggle();
    bit d;
    bit want;
    fetch_request = 1'b1; data_write_sections = WRITE_NONE;
    for (int i = 0; i < 10; i++) begin
      want = (i % 2) == 0;
      data_request = want;
      data_address = $urandom; fetch_address = $urandom;
      do_access(1'b0, d);
      tests_run++;
      if (d !== want) begin
        tests_failed++;
        $display("FAIL toggle[%0d]: got data=%0b expected %0b", i, d, want);
      end
    end
    fetch_request = 1'b0; data_request = 1'b0;
  endtask

  task automatic test_reset_wait();
    fetch_request = 1'b1; fetch_address = 32'h0000_0103; data_request = 1'b0;
    @(posedge clk); #1;          // ISSUE
    @(posedge clk); #1;          // WAIT
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fetch_done !== 1'b0 || fetch_value !== 32'd0 || data_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wait_done: got fd=%0b fv=%h dd=%0b expected 0", fetch_done, fetch_value, data_done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; fetch_request = 1'b0;
    ref_streak = 0;
    @(negedge clk);
    tests_run++;
    if (memory_enable !== 1'b0 || memory_address !== 32'd0 || memory_write_sections !== 3'b000 ||
        memory_write_value !== 32'd0 || fetch_done !== 1'b0 || data_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wait_idle: got en=%0b addr=%h sec=%b val=%h fd=%0b dd=%0b expected zero",
               memory_enable, memory_address, memory_write_sections, memory_write_value, fetch_done, data_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_streak();
    bit d;
    fetch_request = 1'b1; data_request = 1'b1; data_write_sections = WRITE_NONE;
    do_access(1'b0, d);
    do_access(1'b0, d);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_streak = 0;
    test_streak_held(5);
  endtask

  task automatic test_reset_issue();
    bit d;
    logic [31:0] a, v;
    a = $urandom; v = $urandom;
    data_request = 1'b1; data_address = a; data_write_sections = WRITE_WORD; data_write_value = v;
    @(posedge clk); #1;          // ISSUE
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (memory_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_issue_cmd: got en=%0b expected 1", memory_enable);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; data_request = 1'b0;
    ref_mem[a[9:2]] = v;
    ref_streak = 0;
    @(negedge clk);
    tests_run++;
    if (data_done !== 1'b0 || memory_enable !== 1'b0 || memory_address !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_issue_idle: got dd=%0b en=%0b addr=%h expected 0", data_done, memory_enable, memory_address);
    end
    @(posedge clk); #1;
    data_request = 1'b1; data_address = a; data_write_sections = WRITE_NONE;
    do_access(1'b0, d);
    data_request = 1'b0;
  endtask

  task automatic test_random(input int n);
    bit d;
    for (int i = 0; i < n; i++) begin
      fetch_request = 1'($urandom); data_request = 1'($urandom);
      fetch_address = $urandom_range(0, 1023); data_address = $urandom_range(0, 1023);
      data_write_sections = 3'($urandom); data_write_value = $urandom;
      if ($urandom_range(0, 3) == 0) data_write_sections = WRITE_NONE;
      if (fetch_request || data_request) begin
        do_access(1'b1, d);
      end else begin
        @(negedge clk);
        tests_run++;
        if (memory_enable !== 1'b0 || fetch_done !== 1'b0 || data_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_quiet[%0d]: got en=%0b fd=%0b dd=%0b expected 0", i, memory_enable, fetch_done, data_done);
        end
        @(posedge clk); #1;
      end
    end
    fetch_request = 1'b0; data_request = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store_word();
    test_streak_held(10);
    test_toggle();
    test_reset_wait();
    test_reset_streak();
    test_reset_issue();
    test_random(60);
    // Mostly-held requests to push the streak toward its limit.
    for (int k = 0; k < 4; k++) begin
      test_streak_held(5);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port. Requesters hold a request until a one-cycle done pulse. Data accesses win by default; a streak limit prevents fetch starvation. Sits between `core` (plus its stall logic) and the single memory array. Each access is a fixed 3-cycle sequence.

## Interface
- `MAX_DATA_STREAK`, 4: max consecutive data grants while a fetch is pending before fetch is forced through; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `fetch_request` in 1: fetch port wants a word read.
- `fetch_address` in 32: fetch byte address.
- `fetch_done` out 1: one-cycle pulse, fetch complete.
- `fetch_value` out 32: read word, valid only while `fetch_done`=1.
- `data_request` in 1: load/store port wants an access.
- `data_address` in 32: data byte address.
- `data_write_sections` in 3: bit2 writes high half-word, bit1 writes low half-word high byte, bit0 writes low byte; 000 means read.
- `data_write_value` in 32: store data.
- `data_done` out 1: one-cycle pulse, data access complete.
- `data_read_value` out 32: read word, valid only while `data_done`=1.
- `memory_enable` out 1: memory command valid this cycle.
- `memory_address` out 32: word address, bits [1:0] forced to 00.
- `memory_write_sections` out 3: same encoding as `data_write_sections`; 000 for fetch.
- `memory_write_value` out 32: store data to memory.
- `memory_read_value` in 32: memory output, valid the cycle after `memory_enable`.

## Operation
- State machine with three states:
  - **IDLE**: arbitrate.
    - If either request is high, latch the winner's address, write sections and write value, then go to ISSUE.
    - Otherwise stay in IDLE.
  - **ISSUE**: drive the registered memory command with `memory_enable`=1, then go to WAIT.
  - **WAIT**: `memory_enable`=0. Pulse the owner's done output; its value output is `memory_read_value` passed through combinationally. Go to IDLE.
- Arbitration, decided only in IDLE:
  - Only one request high: that requester wins.
  - Both high: data wins unless `streak == MAX_DATA_STREAK`, in which case fetch wins.
- Streak counter, 4 bits, updated at each grant:
  - Data grant with `fetch_request`=1: increment, saturating at `MAX_DATA_STREAK`.
  - Data grant with `fetch_request`=0: clear.
  - Fetch grant: clear.
- Fetch grants always issue a read: `memory_write_sections`=000 and `memory_write_value`=0.
- Writes follow the same sequence. `data_done` pulses in WAIT; `data_read_value` is don't-care for writes.
- The arbiter does no byte lane shifting or sign extension; those stay in the core.
- Requesters must hold their request and operands until done. Inputs are latched at grant, so later changes do not affect the in-flight access.
- A request dropped after grant is a protocol violation. The access still completes and the done pulse is issued.
- Only one done pulse is ever issued per cycle. Fetch and data are never both done.

## Timing
- Latency: request sampled in IDLE at cycle N, `memory_enable` at N+1, done at N+2, back in IDLE at N+3.
- Throughput: at most one access per 3 cycles. A requester still holding its request at N+3 is a new request and is re-arbitrated.
- Reset values: state IDLE, streak 0, `memory_enable`=0, `memory_address`=0, `memory_write_sections`=000, `memory_write_value`=0, `fetch_done`=0, `data_done`=0. `fetch_value` and `data_read_value` are 0 while their done is low.
- Reset mid-operation: `reset_n`=0 sampled in any state returns to IDLE next cycle with no done pulse. A command already driven during ISSUE at that edge is still performed by the memory, including writes. Requesters must reissue after reset.
- Requests arriving during ISSUE or WAIT are not seen until IDLE.
- Both requests rising in the same IDLE cycle: the streak rule alone decides the winner.

## Structure
- Shared package `memory_definitions`:
  - write-section constants `WRITE_NONE` 000, `WRITE_BYTE` 001, `WRITE_HALF` 011, `WRITE_WORD` 111;
  - state encodings `ARBITER_IDLE`, `ARBITER_ISSUE`, `ARBITER_WAIT`.
- One natural sub-module, `grant_selector`: the streak counter plus the priority decision. Inputs are both requests and a grant strobe; outputs are `grant_data` and `grant_fetch`.
- Command and response registers stay in the top level.

## Test plan
- Fetch only, address 0x0000_0103, memory returns 0xDEAD_BEEF → `memory_address`=0x100 with sections 000 at cycle 1; `fetch_done`=1 with `fetch_value`=0xDEAD_BEEF at cycle 2; nothing at cycle 3.
- Store word at 0x40 with value 0x1234_5678 and sections 111 → `memory_enable`=1 with address 0x40, sections 111, value 0x1234_5678 at cycle 1; `data_done` at cycle 2; `fetch_done` stays 0.
- Both requests held continuously, `MAX_DATA_STREAK`=4 → grant order data, data, data, data, fetch, repeating.
- Data request toggles on and off while fetch is held → streak never reaches 4; fetch is served in every gap.
- `reset_n` low during WAIT of a fetch → no `fetch_done`; IDLE next cycle; all outputs at reset values; streak 0.
- `reset_n` low during ISSUE of a store → memory sees the write at that edge; no `data_done`; a fresh data request completes in 3 cycles.
